// File: rtl/req_pending_tracker.sv
// Per-client pending-request counters that feed the priority arbiter's level req bus.
// Optional STARVE_DETECT_EN adds per-client age counters that drive the starve flags.
module req_pending_tracker #(
  parameter int WIDTH        = 3,
  parameter int MAX_PEND     = 3,
  parameter int CNT_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req_pulse,
  input  logic [WIDTH-1:0] grant,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] overflow,
  output logic             spurious,
  output logic [WIDTH-1:0] starve
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] pend_cnt_q [WIDTH];
  logic [CNT_W-1:0] pend_cnt_d [WIDTH];
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic             spurious_q, spurious_d;

  always_comb begin
    spurious_d = 1'b0;
    // clear first so a same-cycle overflow event below wins
    overflow_d = overflow_q & ~{WIDTH{ovf_clr}};
    for (int i = 0; i < WIDTH; i++) begin
      pend_cnt_d[i] = pend_cnt_q[i];
      case ({req_pulse[i], grant[i]})
        2'b10: begin
          if (pend_cnt_q[i] >= MAX_CNT) overflow_d[i] = 1'b1;
          else                          pend_cnt_d[i] = pend_cnt_q[i] + ONE_CNT;
        end
        2'b01: begin
          if (pend_cnt_q[i] == '0) spurious_d    = 1'b1;
          else                     pend_cnt_d[i] = pend_cnt_q[i] - ONE_CNT;
        end
        2'b11: begin
          // strobe accepted, grant retired nothing: count only moves off zero
          if (pend_cnt_q[i] == '0) begin
            pend_cnt_d[i] = ONE_CNT;
            spurious_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) pend_cnt_q[i] <= '0;
      overflow_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) pend_cnt_q[i] <= pend_cnt_d[i];
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < WIDTH; i++) req[i] = (pend_cnt_q[i] != '0);
  end

  assign overflow = overflow_q;
  assign spurious = spurious_q;

`ifdef STARVE_DETECT_EN
  localparam int             AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q [WIDTH];
  logic [AGE_W-1:0] age_d [WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      age_d[i] = age_q[i];
      if (grant[i] || (pend_cnt_q[i] == '0)) age_d[i] = '0;
      else if (age_q[i] < AGE_MAX)           age_d[i] = age_q[i] + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < WIDTH; i++) starve[i] = (age_q[i] == AGE_MAX);
  end
`else
  assign starve = '0;
`endif

endmodule

// File: tb/tb_req_pending_tracker.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_req_pending_tracker;

  localparam int W     = 3;
  localparam int MAXP  = 3;
  localparam int LIMIT = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] req_pulse = '0;
  logic [W-1:0] grant = '0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] req, overflow, starve;
  logic         spurious;

  req_pending_tracker #(.WIDTH(W), .MAX_PEND(MAXP), .CNT_W(2), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .req_pulse(req_pulse), .grant(grant), .ovf_clr(ovf_clr),
    .req(req), .overflow(overflow), .spurious(spurious), .starve(starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] req;
    logic [W-1:0] ovf;
    logic         spur;
    logic [W-1:0] starve;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // reference model state: plain integers
  int      m_cnt [W];
  int      m_age [W];
  bit [W-1:0] m_ovf;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, want);
    end
  endtask

  task automatic step(input logic [W-1:0] s, input logic [W-1:0] g, input logic clr, input logic rst);
    exp_t e;
    bit   spur;
    int   old;
    @(negedge clk);
    req_pulse = s; grant = g; ovf_clr = clr; reset = rst;
    spur = 1'b0;
    if (rst) begin
      for (int i = 0; i < W; i++) begin m_cnt[i] = 0; m_age[i] = 0; end
      m_ovf = '0;
    end else begin
      if (clr) m_ovf = '0;
      for (int i = 0; i < W; i++) begin
        old = m_cnt[i];
        if (g[i] && old == 0) spur = 1'b1;
        if (s[i] && !g[i]) begin
          if (old == MAXP) m_ovf[i] = 1'b1;
          else             m_cnt[i] = old + 1;
        end else if (g[i] && !s[i]) begin
          if (old > 0) m_cnt[i] = old - 1;
        end else if (g[i] && s[i] && old == 0) begin
          m_cnt[i] = 1;
        end
        if (g[i] || old == 0) m_age[i] = 0;
        else if (m_age[i] < LIMIT) m_age[i] = m_age[i] + 1;
      end
    end
    for (int i = 0; i < W; i++) begin
      e.req[i] = (m_cnt[i] != 0);
`ifdef STARVE_DETECT_EN
      e.starve[i] = (m_age[i] == LIMIT);
`else
      e.starve[i] = 1'b0;
`endif
    end
    e.ovf  = m_ovf;
    e.spur = spur;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b0);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req", req, e.req);
        chk("overflow", overflow, e.ovf);
        chk("spurious", {2'b00, spurious}, {2'b00, e.spur});
        chk("starve", starve, e.starve);
      end
    end
  end

  initial begin
    logic [W-1:0] s, g;
    int r;
    for (int i = 0; i < W; i++) begin m_cnt[i] = 0; m_age[i] = 0; end
    m_ovf = '0;

    step('0, '0, 1'b0, 1'b1);
    idle(5);
    // two clients, in-order retirement
    step(3'b101, '0, 1'b0, 1'b0);
    step('0, 3'b001, 1'b0, 1'b0);
    step('0, 3'b100, 1'b0, 1'b0);
    idle(1);
    // saturation and overflow on client 1
    repeat (4) step(3'b010, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    repeat (3) step('0, 3'b010, 1'b0, 1'b0);
    // strobe+grant at saturation, then spurious grant at zero
    repeat (3) step(3'b001, '0, 1'b0, 1'b0);
    step(3'b001, 3'b001, 1'b0, 1'b0);
    repeat (3) step('0, 3'b001, 1'b0, 1'b0);
    step('0, 3'b001, 1'b0, 1'b0);
    idle(2);
    // strobe+grant at zero and ovf_clr racing a new overflow
    step(3'b001, 3'b001, 1'b0, 1'b0);
    repeat (3) step(3'b001, '0, 1'b0, 1'b0);
    step(3'b001, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b1);
    // starvation on client 2
    step(3'b100, '0, 1'b0, 1'b0);
    idle(10);
    step('0, 3'b100, 1'b0, 1'b0);
    idle(2);
    // build cnt={3,2,1}, overflow=001, then reset with a colliding strobe
    repeat (4) step(3'b001, '0, 1'b0, 1'b0);
    repeat (2) step('0, 3'b001, 1'b0, 1'b0);
    repeat (2) step(3'b110, '0, 1'b0, 1'b0);
    step(3'b100, '0, 1'b0, 1'b0);
    step(3'b111, '0, 1'b0, 1'b1);
    idle(2);

    for (int k = 0; k < 600; k++) begin
      s = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) s = '0;
      r = $urandom_range(0, 19);
      if (r < 8)       g = '0;
      else if (r < 19) g = 3'(1 << $urandom_range(0, 2));
      else             g = 3'($urandom_range(0, 7));
      step(s, g, ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
    end
    idle(1);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
